shift_issue_ctrl: RTL and testbench
===================================

Name: shift_issue_ctrl

Overview:
Initiator side of the shift unit's start/done protocol. Accepts one decoded RV32I shift instruction (SLL/SRL/SRA, register or immediate form) from decode via valid/ready. Drives operands and a one-cycle start pulse to the shift unit, captures its result on done, and presents it to writeback via valid/ready. Holds at most one instruction in flight; a timeout guards against a unit that never responds.

Parameters:
TIMEOUT, 16, WAIT-state cycles without fu_done before aborting with error (>=2)
USE_PART, 2'd0, constant driven on fu_use_part (selects shift part)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  decoded shift instruction available
in_ready  out  1  controller can accept instruction
in_rs1_val  in  32  rs1 value (value to shift)
in_rs2_val  in  32  rs2 value (register-form shift amount)
in_shamt  in  5  immediate shift amount
in_is_imm  in  1  1 = immediate form (SLLI/SRLI/SRAI)
in_funct3  in  3  funct3 field
in_funct7_5  in  1  bit 30 of instruction (arith select)
in_rd  in  5  destination register
fu_start  out  1  one-cycle start pulse to shift unit
fu_op1  out  32  operand 1
fu_op2  out  32  operand 2 (amount in [4:0])
fu_use_part  out  2  = USE_PART
fu_op_mode1  out  2  0 = logical, 1 = arithmetic
fu_op_mode2  out  3  = funct3
fu_done  in  1  unit completion, one-cycle pulse
fu_res  in  32  unit result, valid only while fu_done=1
wb_valid  out  1  result ready for writeback
wb_ready  in  1  writeback accepts
wb_rd  out  5  destination register
wb_data  out  32  result
wb_err  out  1  1 = illegal encoding or timeout; wb_data=0
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high.
- Reset: state=IDLE; fu_start, fu_op1, fu_op2, fu_op_mode1, fu_op_mode2, wb_valid, wb_rd, wb_data, wb_err, timer all 0; in_ready=1 from the first cycle after reset; fu_use_part=USE_PART always.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: in_ready=1. On in_valid: latch op1=in_rs1_val; op2 = in_is_imm ? {27'b0,in_shamt} : {27'b0,in_rs2_val[4:0]}; op_mode2=in_funct3; op_mode1={1'b0,in_funct7_5}; rd=in_rd.
  - Legal: funct3=001 with funct7_5=0, or funct3=101 (either funct7_5) -> ISSUE.
  - Otherwise -> WB with wb_err=1, wb_data=0; fu_start is never pulsed.
- ISSUE: fu_start=1 for exactly this cycle; timer=0; -> WAIT.
- fu_op1/op2/op_mode1/op_mode2 stable from ISSUE through end of WAIT; they hold their last value afterwards.
- WAIT: fu_start=0.
  - fu_done=1: capture fu_res into wb_data (forced 0 if rd=0), wb_err=0 -> WB.
  - Else timer+1; when timer reaches TIMEOUT-1 without done: wb_err=1, wb_data=0 -> WB.
  - Done on the same cycle as the final timer count wins (normal completion).
- WB: wb_valid=1; wb_rd/wb_data/wb_err stable until wb_valid&&wb_ready. On handshake -> IDLE next cycle with wb_valid=0. in_ready=0 in WB.
- fu_done in IDLE, ISSUE or WB is ignored (no state or data change).
- Latency, single-cycle unit: in handshake at cycle N; fu_start at N+1; fu_done at N+2; wb_valid at N+3. Minimum 4 cycles per instruction; no overlap.
- Reset mid-operation (any state): return to IDLE, drop the instruction, no wb_valid. A late fu_done after reset is ignored.
- Width: only op2[4:0] is nonzero; rs2 upper bits are discarded.

Test Plan:
- SLLI: rs1=0x0000_0001, shamt=4, rd=5, unit returns 0x10 one cycle after start -> fu_start high exactly one cycle with op2=4, op_mode1=0, op_mode2=001; wb_valid 3 cycles after accept, wb_rd=5, wb_data=0x10, wb_err=0.
- SRA register form: rs1=0x8000_0000, rs2=0xFFFF_FFE4, funct3=101, funct7_5=1 -> fu_op2=0x4, fu_op_mode1=1; unit result 0xF800_0000 appears on wb_data.
- Illegal funct3=000 -> no fu_start; wb_valid next cycle with wb_err=1, wb_data=0; also funct3=001 with funct7_5=1 gives the same response.
- Timeout, TIMEOUT=16, fu_done held 0 -> wb_err=1 after 16 WAIT cycles; a fu_done arriving later in WB leaves wb_data=0.
- Backpressure: wb_ready low 5 cycles -> wb_valid, wb_rd, wb_data held stable; in_ready=0 throughout; new in_valid not accepted until 1 cycle after the wb handshake.
- rst pulsed during WAIT, then fu_done pulsed -> no wb_valid, state IDLE, in_ready=1; rd=0 instruction returns wb_data=0 regardless of fu_res.

Source files
------------

// File: rtl/shift_issue_ctrl.sv
// Shift-unit issue controller: accepts one decoded RV32I shift, drives the unit's
// start/done handshake and hands the result (or an error) to writeback.
module shift_issue_ctrl #(
   parameter int         TIMEOUT  = 16,
   parameter logic [1:0] USE_PART = 2'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_rs1_val,
   input  logic [31:0] in_rs2_val,
   input  logic [4:0]  in_shamt,
   input  logic        in_is_imm,
   input  logic [2:0]  in_funct3,
   input  logic        in_funct7_5,
   input  logic [4:0]  in_rd,
   output logic        fu_start,
   output logic [31:0] fu_op1,
   output logic [31:0] fu_op2,
   output logic [1:0]  fu_use_part,
   output logic [1:0]  fu_op_mode1,
   output logic [2:0]  fu_op_mode2,
   input  logic        fu_done,
   input  logic [31:0] fu_res,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        wb_err,
   output logic        busy
);

   localparam int            TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      WB    = 2'd3
   } state_t;

   state_t        state_r, state_nxt_s;
   logic [TW-1:0] timer_r, timer_nxt_s;
   logic          in_ready_r, in_ready_nxt_s;
   logic          busy_r, busy_nxt_s;
   logic          fu_start_r, fu_start_nxt_s;
   logic [31:0]   fu_op1_r, fu_op1_nxt_s;
   logic [31:0]   fu_op2_r, fu_op2_nxt_s;
   logic [1:0]    fu_op_mode1_r, fu_op_mode1_nxt_s;
   logic [2:0]    fu_op_mode2_r, fu_op_mode2_nxt_s;
   logic          wb_valid_r, wb_valid_nxt_s;
   logic [4:0]    wb_rd_r, wb_rd_nxt_s;
   logic [31:0]   wb_data_r, wb_data_nxt_s;
   logic          wb_err_r, wb_err_nxt_s;
   logic          unused_rs2_hi_s;

   // Only SLL (funct7_5=0) and SRL/SRA are encodings the shift unit understands.
   function automatic logic is_legal_shift(input logic [2:0] funct3, input logic funct7_5);
      return ((funct3 == 3'b001) && (funct7_5 == 1'b0)) || (funct3 == 3'b101);
   endfunction

   assign unused_rs2_hi_s = ^in_rs2_val[31:5];

   // Next-state and next-output decode for the issue/wait/writeback sequence
   always_comb begin
      state_nxt_s       = state_r;
      timer_nxt_s       = timer_r;
      fu_start_nxt_s    = 1'b0;
      fu_op1_nxt_s      = fu_op1_r;
      fu_op2_nxt_s      = fu_op2_r;
      fu_op_mode1_nxt_s = fu_op_mode1_r;
      fu_op_mode2_nxt_s = fu_op_mode2_r;
      wb_valid_nxt_s    = wb_valid_r;
      wb_rd_nxt_s       = wb_rd_r;
      wb_data_nxt_s     = wb_data_r;
      wb_err_nxt_s      = wb_err_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               fu_op1_nxt_s      = in_rs1_val;
               fu_op2_nxt_s      = in_is_imm ? {27'd0, in_shamt} : {27'd0, in_rs2_val[4:0]};
               fu_op_mode1_nxt_s = {1'b0, in_funct7_5};
               fu_op_mode2_nxt_s = in_funct3;
               wb_rd_nxt_s       = in_rd;
               wb_data_nxt_s     = 32'd0;
               if (is_legal_shift(in_funct3, in_funct7_5)) begin
                  state_nxt_s    = ISSUE;
                  fu_start_nxt_s = 1'b1;
                  wb_err_nxt_s   = 1'b0;
               end else begin
                  state_nxt_s    = WB;
                  wb_valid_nxt_s = 1'b1;
                  wb_err_nxt_s   = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         ISSUE: begin
            timer_nxt_s = {TW{1'b0}};
            state_nxt_s = WAIT;
         end
         WAIT: begin
            // A done arriving on the last timer count still counts as completion.
            if (fu_done) begin
               wb_data_nxt_s  = (wb_rd_r == 5'd0) ? 32'd0 : fu_res;
               wb_err_nxt_s   = 1'b0;
               wb_valid_nxt_s = 1'b1;
               state_nxt_s    = WB;
            end else if (timer_r == TIMER_LAST) begin
               wb_data_nxt_s  = 32'd0;
               wb_err_nxt_s   = 1'b1;
               wb_valid_nxt_s = 1'b1;
               state_nxt_s    = WB;
            end else begin
               timer_nxt_s = timer_r + TIMER_ONE;
            end
         end
         WB: begin
            if (wb_ready) begin
               wb_valid_nxt_s = 1'b0;
               state_nxt_s    = IDLE;
            end else begin
               state_nxt_s = WB;
            end
         end
         default: begin
            state_nxt_s    = IDLE;
            wb_valid_nxt_s = 1'b0;
         end
      endcase
      in_ready_nxt_s = (state_nxt_s == IDLE);
      busy_nxt_s     = (state_nxt_s != IDLE);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Timer, operand and writeback output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_r       <= {TW{1'b0}};
         in_ready_r    <= 1'b1;
         busy_r        <= 1'b0;
         fu_start_r    <= 1'b0;
         fu_op1_r      <= 32'd0;
         fu_op2_r      <= 32'd0;
         fu_op_mode1_r <= 2'd0;
         fu_op_mode2_r <= 3'd0;
         wb_valid_r    <= 1'b0;
         wb_rd_r       <= 5'd0;
         wb_data_r     <= 32'd0;
         wb_err_r      <= 1'b0;
      end else begin
         timer_r       <= timer_nxt_s;
         in_ready_r    <= in_ready_nxt_s;
         busy_r        <= busy_nxt_s;
         fu_start_r    <= fu_start_nxt_s;
         fu_op1_r      <= fu_op1_nxt_s;
         fu_op2_r      <= fu_op2_nxt_s;
         fu_op_mode1_r <= fu_op_mode1_nxt_s;
         fu_op_mode2_r <= fu_op_mode2_nxt_s;
         wb_valid_r    <= wb_valid_nxt_s;
         wb_rd_r       <= wb_rd_nxt_s;
         wb_data_r     <= wb_data_nxt_s;
         wb_err_r      <= wb_err_nxt_s;
      end
   end

   assign in_ready    = in_ready_r;
   assign busy        = busy_r;
   assign fu_start    = fu_start_r;
   assign fu_op1      = fu_op1_r;
   assign fu_op2      = fu_op2_r;
   assign fu_use_part = USE_PART;
   assign fu_op_mode1 = fu_op_mode1_r;
   assign fu_op_mode2 = fu_op_mode2_r;
   assign wb_valid    = wb_valid_r;
   assign wb_rd       = wb_rd_r;
   assign wb_data     = wb_data_r;
   assign wb_err      = wb_err_r;

endmodule

// File: tb/tb_shift_issue_ctrl.sv
// Bench for shift_issue_ctrl: directed and random shifts against a shift-unit model
// and an arithmetic reference of the expected writeback response.
module tb_shift_issue_ctrl;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_rs1_val;
   logic [31:0] in_rs2_val;
   logic [4:0]  in_shamt;
   logic        in_is_imm;
   logic [2:0]  in_funct3;
   logic        in_funct7_5;
   logic [4:0]  in_rd;
   logic        fu_start;
   logic [31:0] fu_op1;
   logic [31:0] fu_op2;
   logic [1:0]  fu_use_part;
   logic [1:0]  fu_op_mode1;
   logic [2:0]  fu_op_mode2;
   logic        fu_done;
   logic [31:0] fu_res;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_err;
   logic        busy;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   shift_issue_ctrl #(.TIMEOUT(TIMEOUT), .USE_PART(2'd0)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_shamt(in_shamt),
      .in_is_imm(in_is_imm), .in_funct3(in_funct3), .in_funct7_5(in_funct7_5), .in_rd(in_rd),
      .fu_start(fu_start), .fu_op1(fu_op1), .fu_op2(fu_op2), .fu_use_part(fu_use_part),
      .fu_op_mode1(fu_op_mode1), .fu_op_mode2(fu_op_mode2),
      .fu_done(fu_done), .fu_res(fu_res),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_err(wb_err), .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // RV32I shift semantics: funct3 001 = SLL, 101 = SRL/SRA chosen by bit 30.
   function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [4:0] a,
                                             input logic [2:0] f3, input logic arith);
      if (f3 == 3'b001) return v << a;
      else if (arith) return $unsigned($signed(v) >>> a);
      else return v >> a;
   endfunction

   task automatic drive_garbage();
      in_rs1_val  = $urandom();
      in_rs2_val  = $urandom();
      in_shamt    = 5'($urandom_range(0, 31));
      in_is_imm   = 1'($urandom_range(0, 1));
      in_funct3   = 3'($urandom_range(0, 7));
      in_funct7_5 = 1'($urandom_range(0, 1));
      in_rd       = 5'($urandom_range(0, 31));
   endtask

   // Entry and exit at a falling edge with the controller idle. delay = WAIT cycle
   // on which the unit answers (> TIMEOUT: never); bp = cycles of wb backpressure.
   task automatic run_instr(input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] shamt,
                            input logic is_imm, input logic [2:0] f3, input logic f7,
                            input logic [4:0] rd, input int delay, input int bp);
      logic        legal;
      logic [4:0]  amt;
      logic        exp_err;
      logic [31:0] exp_data;
      int          kmax;
      legal    = (f3 == 3'b101) || ((f3 == 3'b001) && (f7 == 1'b0));
      amt      = is_imm ? shamt : rs2[4:0];
      exp_err  = !legal || (delay > TIMEOUT);
      exp_data = (exp_err || rd == 5'd0) ? 32'd0 : ref_shift(rs1, amt, f3, f7);
      kmax     = (delay > TIMEOUT) ? TIMEOUT : delay;

      chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_rs1_val = rs1; in_rs2_val = rs2; in_shamt = shamt;
      in_is_imm = is_imm; in_funct3 = f3; in_funct7_5 = f7; in_rd = rd;
      @(negedge clk);
      in_valid = 1'b0;
      drive_garbage();
      if (legal) begin
         chk("fu_start_issue", {31'd0, fu_start}, 32'd1);
         chk("fu_op1", fu_op1, rs1);
         chk("fu_op2", fu_op2, {27'd0, amt});
         chk("fu_op_mode1", {30'd0, fu_op_mode1}, {31'd0, f7});
         chk("fu_op_mode2", {29'd0, fu_op_mode2}, {29'd0, f3});
         chk("in_ready_issue", {31'd0, in_ready}, 32'd0);
         chk("wb_valid_issue", {31'd0, wb_valid}, 32'd0);
         for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            chk("fu_start_wait", {31'd0, fu_start}, 32'd0);
            chk("wb_valid_wait", {31'd0, wb_valid}, 32'd0);
            chk("op1_stable", fu_op1, rs1);
            chk("op2_stable", fu_op2, {27'd0, amt});
            chk("busy_wait", {31'd0, busy}, 32'd1);
            fu_done = (k == delay);
            fu_res  = (k == delay) ? ref_shift(fu_op1, fu_op2[4:0], fu_op_mode2, fu_op_mode1[0])
                                   : $urandom();
         end
         @(negedge clk);
         fu_done = 1'b0;
      end else begin
         chk("fu_start_illegal", {31'd0, fu_start}, 32'd0);
      end
      for (int b = 0; b <= bp; b++) begin
         chk("wb_valid", {31'd0, wb_valid}, 32'd1);
         chk("wb_rd", {27'd0, wb_rd}, {27'd0, rd});
         chk("wb_data", wb_data, exp_data);
         chk("wb_err", {31'd0, wb_err}, {31'd0, exp_err});
         chk("in_ready_wb", {31'd0, in_ready}, 32'd0);
         chk("fu_start_wb", {31'd0, fu_start}, 32'd0);
         if (b < bp) begin
            wb_ready = 1'b0;
            in_valid = 1'b1;
            fu_done  = (b == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            fu_res   = $urandom() | 32'h1;
            @(negedge clk);
         end else begin
            wb_ready = 1'b1;
            in_valid = 1'b0;
            fu_done  = 1'b0;
         end
      end
      @(negedge clk);
      wb_ready = 1'b0;
      chk("wb_valid_drop", {31'd0, wb_valid}, 32'd0);
      chk("in_ready_back", {31'd0, in_ready}, 32'd1);
      chk("busy_idle", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [2:0] f3;
      logic [4:0] rd;
      int         d;
      int         sel;
      rst = 1'b1; in_valid = 1'b0; fu_done = 1'b0; fu_res = 32'd0; wb_ready = 1'b0;
      drive_garbage();
      @(negedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fu_start", {31'd0, fu_start}, 32'd0);
      chk("rst_fu_op1", fu_op1, 32'd0);
      chk("rst_fu_op2", fu_op2, 32'd0);
      chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      chk("rst_wb_err", {31'd0, wb_err}, 32'd0);
      chk("use_part", {30'd0, fu_use_part}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Stray done while idle must be ignored.
      fu_done = 1'b1; fu_res = 32'hDEAD_BEEF;
      @(negedge clk);
      fu_done = 1'b0;
      chk("idle_done_busy", {31'd0, busy}, 32'd0);
      chk("idle_done_wbv", {31'd0, wb_valid}, 32'd0);

      run_instr(32'h0000_0001, 32'h0, 5'd4, 1'b1, 3'b001, 1'b0, 5'd5, 1, 0);
      run_instr(32'h8000_0000, 32'hFFFF_FFE4, 5'd0, 1'b0, 3'b101, 1'b1, 5'd7, 1, 0);
      run_instr(32'h1234_5678, 32'h3, 5'd3, 1'b0, 3'b000, 1'b0, 5'd9, 1, 0);
      run_instr(32'h1234_5678, 32'h3, 5'd3, 1'b1, 3'b001, 1'b1, 5'd9, 1, 0);
      run_instr(32'hCAFE_F00D, 32'h5, 5'd5, 1'b0, 3'b101, 1'b0, 5'd3, 100, 2);
      run_instr(32'hF0F0_1234, 32'h7, 5'd1, 1'b0, 3'b101, 1'b1, 5'd12, TIMEOUT, 0);
      run_instr(32'hA5A5_A5A5, 32'h9, 5'd2, 1'b1, 3'b101, 1'b0, 5'd20, 2, 5);
      run_instr(32'hFFFF_FFFF, 32'h1F, 5'd0, 1'b0, 3'b001, 1'b0, 5'd0, 3, 1);

      // Reset during WAIT, then a late done: no writeback may appear.
      in_valid = 1'b1; in_rs1_val = 32'h0000_00FF; in_rs2_val = 32'h2; in_is_imm = 1'b0;
      in_funct3 = 3'b001; in_funct7_5 = 1'b0; in_rd = 5'd4;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_op1", fu_op1, 32'd0);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      fu_done = 1'b1; fu_res = 32'h0000_03FC;
      @(negedge clk);
      fu_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("midrst_wbv", {31'd0, wb_valid}, 32'd0);
         chk("midrst_busy", {31'd0, busy}, 32'd0);
         chk("midrst_rdy", {31'd0, in_ready}, 32'd1);
         chk("midrst_start", {31'd0, fu_start}, 32'd0);
         @(negedge clk);
      end

      for (int n = 0; n < 40; n++) begin
         sel = $urandom_range(0, 4);
         f3  = (sel == 0) ? 3'b001 : (sel <= 2) ? 3'b101 : 3'($urandom_range(0, 7));
         rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         d   = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 6);
         run_instr($urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   f3, 1'($urandom_range(0, 1)), rd, d, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
